// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM encoding and parity selectors.
package uart_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty/count; read data is a combinational view of the head entry.
module sync_fifo #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PTRWIDTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic                rd_en,
    output logic [WIDTH-1:0]    rd_data_c,
    output logic                full,
    output logic                empty,
    output logic [PTRWIDTH:0]   count
);

    localparam int unsigned DEPTH = 2 ** PTRWIDTH;
    localparam int unsigned CNT_W = PTRWIDTH + 1;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [PTRWIDTH-1:0] wr_ptr;
    logic [PTRWIDTH-1:0] rd_ptr;
    logic                wr_ok_c;
    logic                rd_ok_c;
    logic [CNT_W-1:0]    count_nxt_c;

    // A write seen while full is dropped even if a pop happens on the same edge.
    assign wr_ok_c   = wr_en && !full;
    assign rd_ok_c   = rd_en && !empty;
    assign rd_data_c = mem[rd_ptr];

    always_comb begin
        count_nxt_c = count;
        if (wr_ok_c && !rd_ok_c) begin
            count_nxt_c = count + CNT_W'(1);
        end else if (!wr_ok_c && rd_ok_c) begin
            count_nxt_c = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (wr_ok_c) wr_ptr <= wr_ptr + PTRWIDTH'(1);
            if (rd_ok_c) rd_ptr <= rd_ptr + PTRWIDTH'(1);
            count <= count_nxt_c;
            full  <= (count_nxt_c == CNT_W'(DEPTH));
            empty <= (count_nxt_c == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok_c) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: queued frames with per-entry parity/stop settings, serialised back-to-back.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 8,
    parameter int unsigned PTRWIDTH  = 4,
    parameter int unsigned PSWIDTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATAWIDTH-1:0] P_DATA,
    input  logic                 DATA_VALID,
    input  logic                 PAR_EN,
    input  logic                 PAR_TYP,
    input  logic                 STOP2,
    input  logic [PSWIDTH-1:0]   PRESCALE,
    output logic                 TX_OUT,
    output logic                 Busy,
    output logic                 FULL,
    output logic                 EMPTY,
    output logic [PTRWIDTH:0]    COUNT,
    output logic                 OVF
);

    localparam int unsigned ENTRY_W = DATAWIDTH + 3;
    localparam int unsigned BIT_W   = $clog2(DATAWIDTH);

    state_t               state;
    logic [PSWIDTH-1:0]   cnt;
    logic [PSWIDTH-1:0]   ps_lat;
    logic [DATAWIDTH-1:0] shreg;
    logic [BIT_W-1:0]     bit_idx;
    logic                 par_en_r;
    logic                 parity_r;
    logic                 stop2_r;
    logic                 stop_idx;

    logic [ENTRY_W-1:0]   entry_c;
    logic                 tick_c;
    logic                 last_stop_c;
    logic                 pop_c;

    sync_fifo #(
        .WIDTH    (ENTRY_W),
        .PTRWIDTH (PTRWIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .wr_en     (DATA_VALID),
        .wr_data   ({STOP2, PAR_TYP, PAR_EN, P_DATA}),
        .rd_en     (pop_c),
        .rd_data_c (entry_c),
        .full      (FULL),
        .empty     (EMPTY),
        .count     (COUNT)
    );

    assign tick_c      = (cnt == ps_lat);
    assign last_stop_c = !stop2_r || stop_idx;
    // Pop either from idle or on the final stop-bit clock so the next start bit follows with no gap.
    assign pop_c       = !EMPTY && ((state == IDLE) || ((state == STOP) && tick_c && last_stop_c));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            ps_lat   <= '0;
            shreg    <= '0;
            bit_idx  <= '0;
            par_en_r <= 1'b0;
            parity_r <= 1'b0;
            stop2_r  <= 1'b0;
            stop_idx <= 1'b0;
            TX_OUT   <= 1'b1;
            Busy     <= 1'b0;
            OVF      <= 1'b0;
        end else begin
            OVF <= DATA_VALID && FULL;
            unique case (state)
                IDLE: begin
                    TX_OUT <= 1'b1;
                    cnt    <= '0;
                    if (pop_c) begin
                        state  <= START;
                        Busy   <= 1'b1;
                        TX_OUT <= 1'b0;
                    end
                end
                START: begin
                    if (tick_c) begin
                        cnt     <= '0;
                        state   <= DATA;
                        bit_idx <= '0;
                        TX_OUT  <= shreg[0];
                    end else begin
                        cnt <= cnt + PSWIDTH'(1);
                    end
                end
                DATA: begin
                    if (tick_c) begin
                        cnt <= '0;
                        if (bit_idx == BIT_W'(DATAWIDTH - 1)) begin
                            if (par_en_r) begin
                                state  <= PARITY;
                                TX_OUT <= parity_r;
                            end else begin
                                state    <= STOP;
                                stop_idx <= 1'b0;
                                TX_OUT   <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + BIT_W'(1);
                            shreg   <= shreg >> 1;
                            TX_OUT  <= shreg[1];
                        end
                    end else begin
                        cnt <= cnt + PSWIDTH'(1);
                    end
                end
                PARITY: begin
                    if (tick_c) begin
                        cnt      <= '0;
                        state    <= STOP;
                        stop_idx <= 1'b0;
                        TX_OUT   <= 1'b1;
                    end else begin
                        cnt <= cnt + PSWIDTH'(1);
                    end
                end
                STOP: begin
                    if (tick_c) begin
                        cnt <= '0;
                        if (!last_stop_c) begin
                            stop_idx <= 1'b1;
                        end else if (pop_c) begin
                            state  <= START;
                            TX_OUT <= 1'b0;
                        end else begin
                            state  <= IDLE;
                            Busy   <= 1'b0;
                            TX_OUT <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + PSWIDTH'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    Busy   <= 1'b0;
                    TX_OUT <= 1'b1;
                    cnt    <= '0;
                end
            endcase
            // Frame settings and prescale are captured once per frame at pop time.
            if (pop_c) begin
                shreg    <= entry_c[DATAWIDTH-1:0];
                par_en_r <= entry_c[DATAWIDTH];
                parity_r <= (^entry_c[DATAWIDTH-1:0]) ^ (entry_c[DATAWIDTH+1] == PAR_ODD);
                stop2_r  <= entry_c[DATAWIDTH+2];
                ps_lat   <= PRESCALE;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: 8-bit and 5-bit instances on a shared clock and reset.
module tb_uart_tx_buffered;

    logic       clk = 1'b0;
    logic       rst;

    logic [7:0] p_data;
    logic       data_valid, par_en, par_typ, stop2;
    logic [3:0] prescale;
    logic       tx_out, busy, full, empty, ovf;
    logic [4:0] count;

    logic [4:0] d5;
    logic       dv5, pe5, pt5, s25;
    logic [3:0] ps5;
    logic       tx5, busy5, full5, empty5, ovf5;
    logic [4:0] cnt5;

    int total = 0;
    int bad   = 0;

    bit seq1 [0:10] = '{0,0,0,1,1,0,0,1,1,0,1};
    bit seq2 [0:11] = '{0,1,0,1,0,1,1,1,1,1,1,1};
    bit seq4 [0:21] = '{0,0,0,0,0,0,0,0,0,0,1, 0,1,0,0,0,0,0,0,0,0,1};
    bit seq6 [0:7]  = '{0,0,1,1,0,1,0,1};
    logic [7:0] dq [16];

    always #5 clk = ~clk;

    uart_tx_buffered #(.DATAWIDTH(8), .PTRWIDTH(4), .PSWIDTH(4)) dut8 (
        .clk(clk), .rst(rst), .P_DATA(p_data), .DATA_VALID(data_valid),
        .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2), .PRESCALE(prescale),
        .TX_OUT(tx_out), .Busy(busy), .FULL(full), .EMPTY(empty),
        .COUNT(count), .OVF(ovf)
    );

    uart_tx_buffered #(.DATAWIDTH(5), .PTRWIDTH(4), .PSWIDTH(4)) dut5 (
        .clk(clk), .rst(rst), .P_DATA(d5), .DATA_VALID(dv5),
        .PAR_EN(pe5), .PAR_TYP(pt5), .STOP2(s25), .PRESCALE(ps5),
        .TX_OUT(tx5), .Busy(busy5), .FULL(full5), .EMPTY(empty5),
        .COUNT(cnt5), .OVF(ovf5)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr8(input logic [7:0] d, input logic pe, input logic pt, input logic s2);
        p_data     = d;
        par_en     = pe;
        par_typ    = pt;
        stop2      = s2;
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        logic       expb;
        bit         seen;

        rst = 1'b0;
        p_data = '0; data_valid = 1'b0; par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0; prescale = '0;
        d5 = '0; dv5 = 1'b0; pe5 = 1'b0; pt5 = 1'b0; s25 = 1'b0; ps5 = '0;
        step();
        step();

        // Reset state
        check("rst_tx",    32'(tx_out), 32'(1));
        check("rst_busy",  32'(busy),   32'(0));
        check("rst_full",  32'(full),   32'(0));
        check("rst_empty", 32'(empty),  32'(1));
        check("rst_count", 32'(count),  32'(0));
        check("rst_ovf",   32'(ovf),    32'(0));
        check("rst5_tx",   32'(tx5),    32'(1));
        check("rst5_empty",32'(empty5), 32'(1));
        check("rst5_full", 32'(full5),  32'(0));
        check("rst5_ovf",  32'(ovf5),   32'(0));
        check("rst5_count",32'(cnt5),   32'(0));
        rst = 1'b1;
        step();

        // 0xCC, even parity, one stop bit, PRESCALE=0
        wr8(8'hCC, 1'b1, 1'b0, 1'b0);
        check("t1_empty_after_wr", 32'(empty), 32'(0));
        check("t1_busy_after_wr",  32'(busy),  32'(0));
        check("t1_tx_after_wr",    32'(tx_out),32'(1));
        step();
        for (int i = 0; i < 11; i++) begin
            check("t1_tx",   32'(tx_out), 32'(seq1[i]));
            check("t1_busy", 32'(busy),   32'(1));
            if (i == 0) check("t1_empty_after_pop", 32'(empty), 32'(1));
            step();
        end
        check("t1_busy_end", 32'(busy),   32'(0));
        check("t1_tx_end",   32'(tx_out), 32'(1));
        check("t1_empty_end",32'(empty),  32'(1));

        // 0xF5, odd parity, two stop bits, PRESCALE=3; mid-frame prescale change ignored
        prescale = 4'd3;
        wr8(8'hF5, 1'b1, 1'b1, 1'b1);
        step();
        for (int i = 0; i < 48; i++) begin
            if (i == 5) prescale = 4'd0;
            check("t2_tx",   32'(tx_out), 32'(seq2[i/4]));
            check("t2_busy", 32'(busy),   32'(1));
            step();
        end
        check("t2_busy_end", 32'(busy), 32'(0));

        // Fill during a long frame, overflow, then 16 back-to-back frames
        prescale = 4'd15;
        wr8(8'hA5, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 16; j++) begin
            dq[j] = 8'(j * 37 + 11);
            wr8(dq[j], 1'b0, 1'b0, 1'b0);
        end
        prescale = 4'd0;
        check("t3_count_full", 32'(count), 32'(16));
        check("t3_full",       32'(full),  32'(1));
        check("t3_ovf_before", 32'(ovf),   32'(0));
        wr8(8'h3C, 1'b0, 1'b0, 1'b0);
        check("t3_ovf_pulse",  32'(ovf),   32'(1));
        check("t3_count_kept", 32'(count), 32'(16));
        step();
        check("t3_ovf_clear",  32'(ovf),   32'(0));
        seen = 1'b0;
        for (int w = 0; w < 300 && !seen; w++) begin
            if (count == 5'd15) seen = 1'b1;
            else step();
        end
        check("t3_first_pop_seen", 32'(seen), 32'(1));
        for (int j = 0; j < 16; j++) begin
            d = dq[j];
            for (int b = 0; b < 10; b++) begin
                if (b == 0)      expb = 1'b0;
                else if (b == 9) expb = 1'b1;
                else             expb = d[b-1];
                check("t3_tx",   32'(tx_out), 32'(expb));
                check("t3_busy", 32'(busy),   32'(1));
                if (b == 0) check("t3_count", 32'(count), 32'(15 - j));
                step();
            end
        end
        check("t3_busy_end",  32'(busy),  32'(0));
        check("t3_empty_end", 32'(empty), 32'(1));
        check("t3_full_end",  32'(full),  32'(0));

        // 0x00 even parity then 0x01 odd parity, back-to-back
        wr8(8'h00, 1'b1, 1'b0, 1'b0);
        wr8(8'h01, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 22; i++) begin
            check("t4_tx",   32'(tx_out), 32'(seq4[i]));
            check("t4_busy", 32'(busy),   32'(1));
            step();
        end
        check("t4_busy_end", 32'(busy), 32'(0));

        // Asynchronous reset mid-DATA of frame 2 with 3 entries queued
        wr8(8'hFF, 1'b0, 1'b0, 1'b0);
        wr8(8'h00, 1'b0, 1'b0, 1'b0);
        wr8(8'h55, 1'b0, 1'b0, 1'b0);
        wr8(8'h66, 1'b0, 1'b0, 1'b0);
        wr8(8'h77, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step();
        check("t5_count_pre", 32'(count),  32'(3));
        check("t5_busy_pre",  32'(busy),   32'(1));
        check("t5_tx_pre",    32'(tx_out), 32'(0));
        #2;
        rst = 1'b0;
        #1;
        check("t5_tx_rst",    32'(tx_out), 32'(1));
        check("t5_busy_rst",  32'(busy),   32'(0));
        check("t5_count_rst", 32'(count),  32'(0));
        check("t5_empty_rst", 32'(empty),  32'(1));
        step();
        rst = 1'b1;
        for (int i = 0; i < 25; i++) begin
            step();
            check("t5_tx_quiet",   32'(tx_out), 32'(1));
            check("t5_busy_quiet", 32'(busy),   32'(0));
        end

        // 5-bit instance: 5'b10110 with odd parity
        d5 = 5'b10110; pe5 = 1'b1; pt5 = 1'b1; s25 = 1'b0; ps5 = 4'd0;
        dv5 = 1'b1;
        step();
        dv5 = 1'b0;
        step();
        for (int i = 0; i < 8; i++) begin
            check("t6_tx",   32'(tx5),   32'(seq6[i]));
            check("t6_busy", 32'(busy5), 32'(1));
            step();
        end
        check("t6_busy_end", 32'(busy5), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
